// File: rtl/dram_axi_responder_model.sv
// dram_axi_responder_model: behavioural MIG AXI slave with calibration delay, fixed read latency and byte strobes
// Optional DRAM_MODEL_OOR_CHECK_EN: beats at or beyond the array size answer DECERR with no access
module dram_axi_responder_model #(
   parameter int IdWidth = 4,
   parameter int AddrWidth = 30,
   parameter int DataWidth = 64,
   parameter int MemWords = 4096,
   parameter int ReadLatency = 4,
   parameter int CalibCycles = 16,
   localparam int StrbWidth = DataWidth / 8
) (
   input  logic                 dram_clk_i,
   input  logic                 sys_rst_i,
   output logic                 init_calib_complete,
   input  logic [IdWidth-1:0]   s_axi_awid,
   input  logic [AddrWidth-1:0] s_axi_awaddr,
   input  logic [7:0]           s_axi_awlen,
   input  logic [2:0]           s_axi_awsize,
   input  logic [1:0]           s_axi_awburst,
   input  logic                 s_axi_awlock,
   input  logic [3:0]           s_axi_awcache,
   input  logic [2:0]           s_axi_awprot,
   input  logic [3:0]           s_axi_awqos,
   input  logic                 s_axi_awvalid,
   output logic                 s_axi_awready,
   input  logic [DataWidth-1:0] s_axi_wdata,
   input  logic [StrbWidth-1:0] s_axi_wstrb,
   input  logic                 s_axi_wlast,
   input  logic                 s_axi_wvalid,
   output logic                 s_axi_wready,
   output logic [IdWidth-1:0]   s_axi_bid,
   output logic [1:0]           s_axi_bresp,
   output logic                 s_axi_bvalid,
   input  logic                 s_axi_bready,
   input  logic [IdWidth-1:0]   s_axi_arid,
   input  logic [AddrWidth-1:0] s_axi_araddr,
   input  logic [7:0]           s_axi_arlen,
   input  logic [2:0]           s_axi_arsize,
   input  logic [1:0]           s_axi_arburst,
   input  logic                 s_axi_arlock,
   input  logic [3:0]           s_axi_arcache,
   input  logic [2:0]           s_axi_arprot,
   input  logic [3:0]           s_axi_arqos,
   input  logic                 s_axi_arvalid,
   output logic                 s_axi_arready,
   output logic [IdWidth-1:0]   s_axi_rid,
   output logic [DataWidth-1:0] s_axi_rdata,
   output logic [1:0]           s_axi_rresp,
   output logic                 s_axi_rlast,
   output logic                 s_axi_rvalid,
   input  logic                 s_axi_rready
);
   localparam int Bw = $clog2(StrbWidth);
   localparam int Iw = $clog2(MemWords);
   localparam int Cw = $clog2(CalibCycles + 1);
   localparam int Lw = $clog2(ReadLatency + 1);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   w_state_t w_state, w_nxt;
   r_state_t r_state, r_nxt;
   logic [DataWidth-1:0] mem [MemWords];
   logic [Cw-1:0] cal_cnt;
   logic calib;
   logic [IdWidth-1:0] w_id, r_id;
   logic [AddrWidth-1:0] w_addr, r_addr, w_addr_inc, r_addr_inc, ld_addr;
   logic [7:0] w_len, r_len, w_cnt, r_cnt;
   logic [2:0] w_size, r_size;
   logic [1:0] w_burst, r_burst, r_resp;
   logic [Lw-1:0] lat_cnt;
   logic [DataWidth-1:0] r_data;
   logic w_slv, w_dec, w_ok, r_ok, w_oor, ld_oor, w_last, r_last, w_we, r_ld;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic unused_ok;
   assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_arlock,
                        s_axi_arcache, s_axi_arprot, s_axi_arqos, w_addr, r_addr, ld_addr};
   assign calib = cal_cnt == Cw'(CalibCycles);
   assign init_calib_complete = calib;
   assign s_axi_awready = calib && w_state == W_IDLE;
   assign s_axi_wready = w_state == W_DATA;
   assign s_axi_bvalid = w_state == W_RESP;
   assign s_axi_bid = w_id;
   assign s_axi_bresp = w_dec ? 2'b11 : w_slv ? 2'b10 : 2'b00;
   assign s_axi_arready = calib && r_state == R_IDLE;
   assign s_axi_rvalid = r_state == R_DATA;
   assign s_axi_rid = r_id;
   assign s_axi_rdata = r_data;
   assign s_axi_rresp = r_resp;
   assign s_axi_rlast = s_axi_rvalid && r_last;
   assign aw_hs = s_axi_awready && s_axi_awvalid;
   assign w_hs = s_axi_wready && s_axi_wvalid;
   assign b_hs = s_axi_bvalid && s_axi_bready;
   assign ar_hs = s_axi_arready && s_axi_arvalid;
   assign r_hs = s_axi_rvalid && s_axi_rready;
   assign w_last = w_cnt == w_len;
   assign r_last = r_cnt == r_len;
   assign w_ok = !w_burst[1];
   assign r_ok = !r_burst[1];
   assign w_addr_inc = w_burst[0] ? w_addr + (AddrWidth'(1) << w_size) : w_addr;
   assign r_addr_inc = r_burst[0] ? r_addr + (AddrWidth'(1) << r_size) : r_addr;
   // Registered read data is captured when a beat is loaded, so a same-cycle write is not seen
   assign ld_addr = r_state == R_WAIT ? r_addr : r_addr_inc;
   assign r_ld = (r_state == R_WAIT && lat_cnt == '0) || (r_hs && !r_last);
   assign w_we = w_hs && w_ok && !w_oor && !sys_rst_i;
`ifdef DRAM_MODEL_OOR_CHECK_EN
   assign w_oor = |w_addr[AddrWidth-1:Bw+Iw];
   assign ld_oor = |ld_addr[AddrWidth-1:Bw+Iw];
`else
   assign w_oor = 1'b0;
   assign ld_oor = 1'b0;
`endif
   always_comb begin
      w_nxt = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP : b_hs ? W_IDLE : w_state;
      r_nxt = ar_hs ? R_WAIT : (r_state == R_WAIT && lat_cnt == '0) ? R_DATA : (r_hs && r_last) ? R_IDLE : r_state;
   end
   always_ff @(posedge dram_clk_i) begin
      if (sys_rst_i) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         cal_cnt <= '0;
      end else begin
         w_state <= w_nxt;
         r_state <= r_nxt;
         if (!calib) cal_cnt <= cal_cnt + 1'b1;
      end
   end
   always_ff @(posedge dram_clk_i) begin
      if (sys_rst_i) begin
         {w_id, w_addr, w_len, w_size, w_burst, w_cnt, w_slv, w_dec} <= '0;
         {r_id, r_addr, r_len, r_size, r_burst, r_cnt, lat_cnt, r_data, r_resp} <= '0;
      end else begin
         if (aw_hs) begin
            {w_id, w_addr, w_len, w_size, w_burst} <= {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst};
            w_cnt <= '0;
            w_slv <= s_axi_awburst[1];
            w_dec <= 1'b0;
         end else if (w_hs) begin
            w_addr <= w_addr_inc;
            w_cnt <= w_cnt + 1'b1;
            w_slv <= w_slv | (s_axi_wlast != w_last);
            w_dec <= w_dec | (w_ok && w_oor);
         end
         if (ar_hs) begin
            {r_id, r_addr, r_len, r_size, r_burst} <= {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst};
            r_cnt <= '0;
            lat_cnt <= Lw'(ReadLatency - 1);
         end else if (r_state == R_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
         if (r_hs) begin
            r_addr <= r_addr_inc;
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_ld) begin
            r_data <= (r_ok && !ld_oor) ? mem[ld_addr[Bw +: Iw]] : '0;
            r_resp <= !r_ok ? 2'b10 : ld_oor ? 2'b11 : 2'b00;
         end
      end
   end
   always_ff @(posedge dram_clk_i)
      if (w_we)
         for (int b = 0; b < StrbWidth; b++)
            if (s_axi_wstrb[b]) mem[w_addr[Bw +: Iw]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
endmodule
